// File: rtl/pipe_mem_arbiter.sv
// Shares one single-ported memory between the IF-stage fetch port and the
// MEM-stage data port. Latches each granted transaction, returns registered
// read data with a one-cycle ack, and produces the pipeline-wide stall.
module pipe_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_D_BUSY  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_d;

  logic              w_if_elig;
  logic              w_d_elig;
  logic              w_grant_d;
  logic              w_grant_if;
  logic              w_timeout;
  logic              w_done;
  logic [DATA_W-1:0] w_rdata_cap;

  logic              w_mem_req_nxt;
  logic              w_mem_we_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic              w_if_ack_nxt;
  logic              w_d_ack_nxt;
  logic [DATA_W-1:0] w_if_rdata_nxt;
  logic [DATA_W-1:0] w_d_rdata_nxt;
  logic              w_err_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_last_d_nxt;

  // A requester whose ack is showing this cycle is already served; mask it.
  assign w_if_elig = if_req_i & ~if_ack_o;
  assign w_d_elig  = d_req_i  & ~d_ack_o;

  // Data wins unless both are eligible and data was the last one served.
  assign w_grant_d  = w_d_elig & (~w_if_elig | ~r_last_d);
  assign w_grant_if = w_if_elig & ~w_grant_d;

  // A real memory ack in the deadline cycle beats the timeout.
  assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT)) & ~mem_ack_i;
  assign w_done      = mem_ack_i | w_timeout;
  assign w_rdata_cap = w_timeout ? '0 : mem_rdata_i;

  // Stall whenever either pipeline port waits on an access not yet acked.
  assign stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_D_BUSY;
        end else if (w_grant_if) begin
          w_state_nxt = ST_IF_BUSY;
        end
      end
      ST_IF_BUSY, ST_D_BUSY: begin
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and grant history.
  always_comb begin
    w_mem_req_nxt   = mem_req_o;
    w_mem_we_nxt    = mem_we_o;
    w_mem_addr_nxt  = mem_addr_o;
    w_mem_wdata_nxt = mem_wdata_o;
    w_if_ack_nxt    = 1'b0;
    w_d_ack_nxt     = 1'b0;
    w_if_rdata_nxt  = if_rdata_o;
    w_d_rdata_nxt   = d_rdata_o;
    w_err_nxt       = err_o;
    w_cnt_nxt       = r_cnt;
    w_last_d_nxt    = r_last_d;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = d_we_i;
          w_mem_addr_nxt  = d_addr_i;
          w_mem_wdata_nxt = d_wdata_i;
          w_cnt_nxt       = '0;
          w_last_d_nxt    = 1'b1;
        end else if (w_grant_if) begin
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = if_addr_i;
          w_mem_wdata_nxt = '0;
          w_cnt_nxt       = '0;
          w_last_d_nxt    = 1'b0;
        end
      end
      ST_IF_BUSY: begin
        if (w_done) begin
          w_mem_req_nxt  = 1'b0;
          w_if_ack_nxt   = 1'b1;
          w_if_rdata_nxt = w_rdata_cap;
          w_err_nxt      = err_o | w_timeout;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_D_BUSY: begin
        if (w_done) begin
          w_mem_req_nxt = 1'b0;
          w_d_ack_nxt   = 1'b1;
          w_err_nxt     = err_o | w_timeout;
          if (!mem_we_o) begin
            w_d_rdata_nxt = w_rdata_cap;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  // Output, counter and grant-history registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      err_o       <= 1'b0;
      r_cnt       <= '0;
      r_last_d    <= 1'b0;
    end else begin
      mem_req_o   <= w_mem_req_nxt;
      mem_we_o    <= w_mem_we_nxt;
      mem_addr_o  <= w_mem_addr_nxt;
      mem_wdata_o <= w_mem_wdata_nxt;
      if_ack_o    <= w_if_ack_nxt;
      d_ack_o     <= w_d_ack_nxt;
      if_rdata_o  <= w_if_rdata_nxt;
      d_rdata_o   <= w_d_rdata_nxt;
      err_o       <= w_err_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_d    <= w_last_d_nxt;
    end
  end

endmodule
